// File: rtl/gb_cpu_pkg.sv
// Shared CPU definitions: register/pair select encodings, DMG post-boot values
// and the helpers that map a pair select onto its two byte slots.
package gb_cpu_pkg;

   localparam int unsigned REG_W  = 8;
   localparam int unsigned PAIR_W = 16;
   localparam int unsigned SEL_W  = 3;

   localparam logic [SEL_W-1:0] REG_B   = 3'd0;
   localparam logic [SEL_W-1:0] REG_C   = 3'd1;
   localparam logic [SEL_W-1:0] REG_D   = 3'd2;
   localparam logic [SEL_W-1:0] REG_E   = 3'd3;
   localparam logic [SEL_W-1:0] REG_H   = 3'd4;
   localparam logic [SEL_W-1:0] REG_L   = 3'd5;
   localparam logic [SEL_W-1:0] SEL_BUS = 3'd6;
   localparam logic [SEL_W-1:0] REG_A   = 3'd7;

   // F is stored in slot 6, which no 8-bit port can address (it is the bus slot there)
   localparam logic [SEL_W-1:0] SLOT_F  = 3'd6;

   localparam logic [1:0] PAIR_BC = 2'd0;
   localparam logic [1:0] PAIR_DE = 2'd1;
   localparam logic [1:0] PAIR_HL = 2'd2;
   localparam logic [1:0] PAIR_AF = 2'd3;

   localparam logic [PAIR_W-1:0] BOOT_AF = 16'h01B0;
   localparam logic [PAIR_W-1:0] BOOT_BC = 16'h0013;
   localparam logic [PAIR_W-1:0] BOOT_DE = 16'h00D8;
   localparam logic [PAIR_W-1:0] BOOT_HL = 16'h014D;

   function automatic logic [SEL_W-1:0] pair_hi(input logic [1:0] p);
      case (p)
         PAIR_BC: pair_hi = REG_B;
         PAIR_DE: pair_hi = REG_D;
         PAIR_HL: pair_hi = REG_H;
         default: pair_hi = REG_A;
      endcase
   endfunction

   function automatic logic [SEL_W-1:0] pair_lo(input logic [1:0] p);
      case (p)
         PAIR_BC: pair_lo = REG_C;
         PAIR_DE: pair_lo = REG_E;
         PAIR_HL: pair_lo = REG_L;
         default: pair_lo = SLOT_F;
      endcase
   endfunction

   function automatic logic [REG_W-1:0] reset_byte(input logic post_boot,
                                                   input logic [SEL_W-1:0] slot);
      reset_byte = 8'h00;
      if (post_boot) begin
         case (slot)
            REG_B:   reset_byte = BOOT_BC[15:8];
            REG_C:   reset_byte = BOOT_BC[7:0];
            REG_D:   reset_byte = BOOT_DE[15:8];
            REG_E:   reset_byte = BOOT_DE[7:0];
            REG_H:   reset_byte = BOOT_HL[15:8];
            REG_L:   reset_byte = BOOT_HL[7:0];
            REG_A:   reset_byte = BOOT_AF[15:8];
            default: reset_byte = BOOT_AF[7:0];
         endcase
      end
   endfunction

endpackage

// File: rtl/gb_pair_incdec.sv
// 16-bit +/-1 unit for HL+/HL-, INC rr and DEC rr; wraps modulo 2^16.
module gb_pair_incdec
   import gb_cpu_pkg::*;
(
   input  logic [PAIR_W-1:0] val,
   input  logic              dec,
   output logic [PAIR_W-1:0] res
);

   assign res = dec ? (val - 16'd1) : (val + 16'd1);

endmodule

// File: rtl/gb_regfile_pairs.sv
// CPU general register file with N 8-bit read ports, one 8-bit write port,
// a 16-bit pair read/write port, pair inc/dec and a flag update port.
module gb_regfile_pairs
   import gb_cpu_pkg::*;
#(
   parameter int unsigned NUM_RD    = 2,
   parameter bit          POST_BOOT = 1'b0,
   parameter bit          BYPASS    = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_RD-1:0]         rd_en,
   input  logic [SEL_W*NUM_RD-1:0]   rd_sel,
   output logic [REG_W*NUM_RD-1:0]   rd_data,
   input  logic                      wr_en,
   input  logic [SEL_W-1:0]          wr_sel,
   input  logic [REG_W-1:0]          wr_data,
   input  logic                      pw_en,
   input  logic [1:0]                pw_sel,
   input  logic [PAIR_W-1:0]         pw_data,
   input  logic                      pid_en,
   input  logic [1:0]                pid_sel,
   input  logic                      pid_dec,
   input  logic                      flag_wr_en,
   input  logic [3:0]                flag_in,
   input  logic [1:0]                pr_sel,
   output logic [PAIR_W-1:0]         pr_data,
   output logic [3:0]                flags_out
);

   logic [REG_W-1:0]  regs   [8];
   logic [REG_W-1:0]  nxt    [8];
   logic [REG_W-1:0]  rd_src [8];
   logic [PAIR_W-1:0] pid_cur;
   logic [PAIR_W-1:0] pid_res;

   assign pid_cur = {regs[pair_hi(pid_sel)], regs[pair_lo(pid_sel)]};

   gb_pair_incdec u_incdec (
      .val (pid_cur),
      .dec (pid_dec),
      .res (pid_res)
   );

   // Per-byte priority: later assignments win (pw > pid > wr > flag)
   always_comb begin
      for (int i = 0; i < 8; i++) nxt[i] = regs[i];
      if (!rst) begin
         if (flag_wr_en) nxt[SLOT_F] = {flag_in, 4'h0};
         if (wr_en && (wr_sel != SEL_BUS)) nxt[wr_sel] = wr_data;
         if (pid_en) begin
            nxt[pair_hi(pid_sel)] = pid_res[15:8];
            nxt[pair_lo(pid_sel)] = pid_res[7:0];
         end
         if (pw_en) begin
            nxt[pair_hi(pw_sel)] = pw_data[15:8];
            nxt[pair_lo(pw_sel)] = pw_data[7:0];
         end
      end
      nxt[SLOT_F][3:0] = 4'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= reset_byte(POST_BOOT, 3'(i));
      end else begin
         for (int i = 0; i < 8; i++) regs[i] <= nxt[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) rd_src[i] = BYPASS ? nxt[i] : regs[i];
   end

   for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
      logic [SEL_W-1:0] sel;
      assign sel = rd_sel[SEL_W*k +: SEL_W];
      assign rd_data[REG_W*k +: REG_W] = (rd_en[k] && (sel != SEL_BUS)) ? rd_src[sel] : 8'h00;
   end

   assign pr_data   = {regs[pair_hi(pr_sel)], regs[pair_lo(pr_sel)]};
   assign flags_out = regs[SLOT_F][7:4];

endmodule

// File: tb/tb_gb_regfile_pairs.sv
// Bench for gb_regfile_pairs: a post-boot/bypass instance and a zero-reset/no-bypass
// instance share stimulus and are both compared against a named-register model.
module tb_gb_regfile_pairs;

   localparam int unsigned NR = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     rd_en;
   logic [3*NR-1:0]   rd_sel;
   logic              wr_en;
   logic [2:0]        wr_sel;
   logic [7:0]        wr_data;
   logic              pw_en;
   logic [1:0]        pw_sel;
   logic [15:0]       pw_data;
   logic              pid_en;
   logic [1:0]        pid_sel;
   logic              pid_dec;
   logic              flag_wr_en;
   logic [3:0]        flag_in;
   logic [1:0]        pr_sel;
   logic [8*NR-1:0]   rd0, rd1;
   logic [15:0]       pr0, pr1;
   logic [3:0]        fl0, fl1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gb_regfile_pairs #(.NUM_RD(NR), .POST_BOOT(1'b1), .BYPASS(1'b1)) dut0 (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd0),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .pw_en(pw_en), .pw_sel(pw_sel), .pw_data(pw_data),
      .pid_en(pid_en), .pid_sel(pid_sel), .pid_dec(pid_dec),
      .flag_wr_en(flag_wr_en), .flag_in(flag_in),
      .pr_sel(pr_sel), .pr_data(pr0), .flags_out(fl0));

   gb_regfile_pairs #(.NUM_RD(NR), .POST_BOOT(1'b0), .BYPASS(1'b0)) dut1 (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd1),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .pw_en(pw_en), .pw_sel(pw_sel), .pw_data(pw_data),
      .pid_en(pid_en), .pid_sel(pid_sel), .pid_dec(pid_dec),
      .flag_wr_en(flag_wr_en), .flag_in(flag_in),
      .pr_sel(pr_sel), .pr_data(pr1), .flags_out(fl1));

   typedef struct packed {
      logic [7:0] a, b, c, d, e, h, l;
      logic [3:0] f;
   } st_t;

   localparam st_t BOOT = '{a: 8'h01, b: 8'h00, c: 8'h13, d: 8'h00,
                            e: 8'hD8, h: 8'h01, l: 8'h4D, f: 4'hB};
   st_t m0, m1;

   function automatic logic [7:0] get8(input st_t s, input logic [2:0] sel);
      case (sel)
         3'd0: return s.b;
         3'd1: return s.c;
         3'd2: return s.d;
         3'd3: return s.e;
         3'd4: return s.h;
         3'd5: return s.l;
         3'd7: return s.a;
         default: return 8'h00;
      endcase
   endfunction

   function automatic st_t set8(input st_t s, input logic [2:0] sel, input logic [7:0] v);
      st_t r = s;
      case (sel)
         3'd0: r.b = v;
         3'd1: r.c = v;
         3'd2: r.d = v;
         3'd3: r.e = v;
         3'd4: r.h = v;
         3'd5: r.l = v;
         3'd7: r.a = v;
         default: ;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] getp(input st_t s, input logic [1:0] p);
      case (p)
         2'd0: return {s.b, s.c};
         2'd1: return {s.d, s.e};
         2'd2: return {s.h, s.l};
         default: return {s.a, s.f, 4'h0};
      endcase
   endfunction

   function automatic st_t setp(input st_t s, input logic [1:0] p, input logic [15:0] v);
      st_t r = s;
      case (p)
         2'd0: begin r.b = v[15:8]; r.c = v[7:0]; end
         2'd1: begin r.d = v[15:8]; r.e = v[7:0]; end
         2'd2: begin r.h = v[15:8]; r.l = v[7:0]; end
         default: begin r.a = v[15:8]; r.f = v[7:4]; end
      endcase
      return r;
   endfunction

   // State after the coming edge: apply lowest priority first so higher ones overwrite
   function automatic st_t next_st(input st_t s);
      st_t n = s;
      if (flag_wr_en) n.f = flag_in;
      if (wr_en) n = set8(n, wr_sel, wr_data);
      if (pid_en) n = setp(n, pid_sel, pid_dec ? getp(s, pid_sel) - 16'd1
                                               : getp(s, pid_sel) + 16'd1);
      if (pw_en) n = setp(n, pw_sel, pw_data);
      return n;
   endfunction

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      st_t n0 = rst ? m0 : next_st(m0);
      for (int k = 0; k < int'(NR); k++) begin
         logic [2:0] s = rd_sel[3*k +: 3];
         check_val($sformatf("%s rd0.%0d", tag, k), 16'(rd0[8*k +: 8]),
                   rd_en[k] ? 16'(get8(n0, s)) : 16'h0);
         check_val($sformatf("%s rd1.%0d", tag, k), 16'(rd1[8*k +: 8]),
                   rd_en[k] ? 16'(get8(m1, s)) : 16'h0);
      end
      check_val({tag, " pr0"}, pr0, getp(m0, pr_sel));
      check_val({tag, " pr1"}, pr1, getp(m1, pr_sel));
      check_val({tag, " fl0"}, 16'(fl0), 16'(m0.f));
      check_val({tag, " fl1"}, 16'(fl1), 16'(m1.f));
   endtask

   // Inputs are set at the falling edge; check, cross one rising edge, return at next falling edge
   task automatic step(input string tag);
      if (rst) begin m0 = BOOT; m1 = '0; end
      #1 check_outputs(tag);
      @(posedge clk);
      if (!rst) begin
         m0 = next_st(m0);
         m1 = next_st(m1);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rd_en = '0; rd_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
      pw_en = 1'b0; pw_sel = '0; pw_data = '0; pid_en = 1'b0; pid_sel = '0;
      pid_dec = 1'b0; flag_wr_en = 1'b0; flag_in = '0;
   endtask

   task automatic randomize_inputs();
      rd_en = NR'($urandom); rd_sel = (3*NR)'($urandom);
      wr_en = 1'($urandom); wr_sel = 3'($urandom); wr_data = 8'($urandom);
      pw_en = ($urandom_range(0, 3) == 0); pw_sel = 2'($urandom); pw_data = 16'($urandom);
      pid_en = 1'($urandom); pid_sel = 2'($urandom); pid_dec = 1'($urandom);
      flag_wr_en = 1'($urandom); flag_in = 4'($urandom); pr_sel = 2'($urandom);
   endtask

   initial begin
      idle();
      pr_sel = '0;
      rst = 1'b1;
      m0 = BOOT; m1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 check_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // 8-bit writes build a pair
      wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h12; step("wr_b");
      wr_sel = 3'd1; wr_data = 8'h34; step("wr_c");
      idle(); pr_sel = 2'd0; rd_en = 3'b111; rd_sel = {3'd6, 3'd6, 3'd6};
      #1 check_val("bc_pair1", pr1, 16'h1234);
      check_val("bc_pair0", pr0, 16'h1234);
      check_val("rd_bus", 16'(rd1[7:0]), 16'h0);
      rd_en = 3'b000; rd_sel = {3'd0, 3'd0, 3'd0};
      #1 check_val("rd_dis", 16'(rd0[7:0]), 16'h0);
      step("rd");

      // inc/dec wrap and byte carry
      pw_en = 1'b1; pw_sel = 2'd2; pw_data = 16'h00FF; step("pw_hl");
      idle(); pid_en = 1'b1; pid_sel = 2'd2; step("inc_hl");
      idle(); pr_sel = 2'd2;
      #1 check_val("hl_carry", pr1, 16'h0100);
      pw_en = 1'b1; pw_sel = 2'd2; pw_data = 16'hFFFF; step("pw_hl2");
      idle(); pid_en = 1'b1; pid_sel = 2'd2; step("inc_wrap");
      idle();
      #1 check_val("hl_wrap", pr1, 16'h0000);
      pw_en = 1'b1; pw_sel = 2'd1; pw_data = 16'h0000; step("pw_de");
      idle(); pid_en = 1'b1; pid_sel = 2'd1; pid_dec = 1'b1; step("dec_de");
      idle(); pr_sel = 2'd1;
      #1 check_val("de_wrap", pr1, 16'hFFFF);
      check_val("f_keep0", 16'(fl0), 16'hB);
      check_val("f_keep1", 16'(fl1), 16'h0);

      // priority: pw beats pid beats wr on HL; non-conflicting wr to A commits
      pw_en = 1'b1; pw_sel = 2'd2; pw_data = 16'hAAAA;
      pid_en = 1'b1; pid_sel = 2'd2; wr_en = 1'b1; wr_sel = 3'd5; wr_data = 8'h55;
      step("prio1");
      idle(); pr_sel = 2'd2;
      #1 check_val("prio_pw", pr1, 16'hAAAA);
      pid_en = 1'b1; pid_sel = 2'd2; wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'h77;
      step("prio2");
      idle(); pr_sel = 2'd2; rd_en = 3'b001; rd_sel = {3'd0, 3'd0, 3'd7};
      #1 check_val("prio_pid", pr1, 16'hAAAB);
      check_val("prio_a", 16'(rd1[7:0]), 16'h0077);

      // AF masking and pair-write over flag-write
      idle(); pw_en = 1'b1; pw_sel = 2'd3; pw_data = 16'h12FF; step("pw_af");
      idle(); pr_sel = 2'd3;
      #1 check_val("af_mask", pr1, 16'h12F0);
      check_val("af_flags", 16'(fl1), 16'hF);
      pw_en = 1'b1; pw_sel = 2'd3; pw_data = 16'h34FF; flag_wr_en = 1'b1; flag_in = 4'h0;
      step("af_prio");
      idle(); pr_sel = 2'd3;
      #1 check_val("af_pw_wins", pr1, 16'h34F0);

      // bypass on dut0 versus registered read on dut1
      wr_en = 1'b1; wr_sel = 3'd3; wr_data = 8'h11; step("wr_e");
      wr_data = 8'h9C; rd_en = 3'b111; rd_sel = {3'd3, 3'd7, 3'd3};
      #1 check_val("byp_e0", 16'(rd0[7:0]), 16'h009C);
      check_val("byp_a", 16'(rd0[15:8]), 16'h0034);
      check_val("byp_e2", 16'(rd0[23:16]), 16'h009C);
      check_val("nobyp_e", 16'(rd1[7:0]), 16'h0011);
      step("byp");
      idle(); rd_en = 3'b001; rd_sel = {3'd0, 3'd0, 3'd3};
      #1 check_val("nobyp_next", 16'(rd1[7:0]), 16'h009C);

      // mid-cycle async reset with operations pending
      randomize_inputs(); step("pre_rst");
      #2 rst = 1'b1; m0 = BOOT; m1 = '0;
      for (int p = 0; p < 4; p++) begin
         pr_sel = 2'(p);
         #1 check_val($sformatf("rst_pair%0d", p), pr0, getp(BOOT, 2'(p)));
      end
      check_val("rst_flags", 16'(fl0), 16'hB);
      @(negedge clk);
      pid_en = 1'b1; pw_en = 1'b1; wr_en = 1'b1; flag_wr_en = 1'b1;
      step("rst_hold");
      rst = 1'b0;

      // random soak with occasional resets
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         rst = ($urandom_range(0, 39) == 0);
         step($sformatf("rnd%0d", i));
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
